// File: rtl/w5300_udp_tx_sequencer_pkg.sv
// rtl/w5300_udp_tx_sequencer_pkg.sv - W5300 socket register map, bus op codes and Tx sequencer states
package w5300_udp_tx_sequencer_pkg;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } AddrOperation;

    typedef enum logic [3:0] {
        IDLE,
        RD_FSR0,
        RD_FSR2,
        CHK_FSR,
        FETCH,
        PUSH,
        WR_WRSR0,
        WR_WRSR2,
        WR_CR,
        RD_IR,
        CHK_IR,
        CLR_IR,
        FINISH
    } TxSeqState;

    // Socket 0 offsets; socket n sits 0x40 further up the map.
    localparam logic [9:0] Sn_CR       = 10'h202;
    localparam logic [9:0] Sn_IR       = 10'h206;
    localparam logic [9:0] Sn_TX_WRSR0 = 10'h220;
    localparam logic [9:0] Sn_TX_WRSR2 = 10'h222;
    localparam logic [9:0] Sn_TX_FSR0  = 10'h224;
    localparam logic [9:0] Sn_TX_FSR2  = 10'h226;
    localparam logic [9:0] Sn_TX_FIFOR = 10'h22E;

    localparam logic [15:0] Sn_CR_SEND        = 16'h0020;
    localparam logic [15:0] Sn_IR_IMR_SENDOK  = 16'h0010;
    localparam logic [15:0] Sn_IR_IMR_TIMEOUT = 16'h0008;
    localparam logic [15:0] Sn_IR_CLR_MASK    = Sn_IR_IMR_SENDOK | Sn_IR_IMR_TIMEOUT;
    localparam logic [15:0] Sn_MSSR_UDP       = 16'd1472;
    localparam logic [15:0] UDP_MAX_PAYLOAD   = Sn_MSSR_UDP;

    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] base, input logic [2:0] sock);
        return base + {1'b0, sock, 6'b000000};
    endfunction

endpackage

// File: rtl/w5300_udp_tx_sequencer.sv
// rtl/w5300_udp_tx_sequencer.sv - sends one UDP datagram on a W5300 socket via the shared register port
module w5300_udp_tx_sequencer
    import w5300_udp_tx_sequencer_pkg::*;
#(
    parameter int SOCKET    = 0,
    parameter int MAX_POLLS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  len,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [15:0]  data,
    input  logic         dataValid,
    output logic         dataReady,
    output logic         regReq,
    output AddrOperation regOp,
    output logic [9:0]   regAddr,
    output logic [15:0]  regWData,
    input  logic         regAck,
    input  logic [15:0]  regRData
);

    localparam logic [2:0]  SOCK      = 3'(SOCKET);
    localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);
    localparam logic [15:0] POLL_MAX  = 16'(MAX_POLLS);

    localparam logic [9:0] ADDR_CR    = get_socket_n_reg(Sn_CR, SOCK);
    localparam logic [9:0] ADDR_IR    = get_socket_n_reg(Sn_IR, SOCK);
    localparam logic [9:0] ADDR_WRSR0 = get_socket_n_reg(Sn_TX_WRSR0, SOCK);
    localparam logic [9:0] ADDR_WRSR2 = get_socket_n_reg(Sn_TX_WRSR2, SOCK);
    localparam logic [9:0] ADDR_FSR0  = get_socket_n_reg(Sn_TX_FSR0, SOCK);
    localparam logic [9:0] ADDR_FSR2  = get_socket_n_reg(Sn_TX_FSR2, SOCK);
    localparam logic [9:0] ADDR_FIFOR = get_socket_n_reg(Sn_TX_FIFOR, SOCK);

    TxSeqState   state, nextState;
    logic [15:0] lenR;
    logic [15:0] wordsLeft;
    logic [15:0] pollCnt;
    logic [15:0] wordR;
    logic [15:0] rdR;
    logic        fsrHi;
    logic        okR;
    logic        gap;
    logic        ack;
    logic        lenBad;
    logic        freeOk;
    logic        irOk;
    logic        irTimeout;
    logic [16:0] lenPlus;

    // A request is only acknowledged while it is actually outstanding.
    assign ack       = regAck && regReq;
    assign lenBad    = (len == 16'd0) || (len > UDP_MAX_PAYLOAD);
    assign freeOk    = {fsrHi, rdR} >= {1'b0, lenR};
    assign irOk      = (rdR & Sn_IR_IMR_SENDOK) != 16'd0;
    assign irTimeout = (rdR & Sn_IR_IMR_TIMEOUT) != 16'd0;
    assign lenPlus   = {1'b0, len} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        regReq    = 1'b0;
        regOp     = RD;
        regAddr   = 10'd0;
        regWData  = 16'd0;
        dataReady = 1'b0;
        busy      = (state != IDLE) && (state != FINISH);
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: if (start) nextState = lenBad ? FINISH : RD_FSR0;
            RD_FSR0: begin
                regReq  = !gap;
                regAddr = ADDR_FSR0;
                if (ack) nextState = RD_FSR2;
            end
            RD_FSR2: begin
                regReq  = !gap;
                regAddr = ADDR_FSR2;
                if (ack) nextState = CHK_FSR;
            end
            CHK_FSR: begin
                if (freeOk)                 nextState = FETCH;
                else if (pollCnt >= POLL_LAST) nextState = FINISH;
                else                        nextState = RD_FSR0;
            end
            FETCH: begin
                dataReady = 1'b1;
                if (dataValid) nextState = PUSH;
            end
            PUSH: begin
                regReq   = !gap;
                regOp    = WR;
                regAddr  = ADDR_FIFOR;
                regWData = wordR;
                if (ack) nextState = (wordsLeft == 16'd1) ? WR_WRSR0 : FETCH;
            end
            WR_WRSR0: begin
                regReq  = !gap;
                regOp   = WR;
                regAddr = ADDR_WRSR0;
                if (ack) nextState = WR_WRSR2;
            end
            WR_WRSR2: begin
                regReq   = !gap;
                regOp    = WR;
                regAddr  = ADDR_WRSR2;
                regWData = lenR;
                if (ack) nextState = WR_CR;
            end
            WR_CR: begin
                regReq   = !gap;
                regOp    = WR;
                regAddr  = ADDR_CR;
                regWData = Sn_CR_SEND;
                if (ack) nextState = RD_IR;
            end
            RD_IR: begin
                regReq  = !gap;
                regAddr = ADDR_IR;
                if (ack) nextState = CHK_IR;
            end
            CHK_IR: begin
                if (irOk || irTimeout)         nextState = CLR_IR;
                else if (pollCnt >= POLL_LAST) nextState = FINISH;
                else                           nextState = RD_IR;
            end
            CLR_IR: begin
                regReq   = !gap;
                regOp    = WR;
                regAddr  = ADDR_IR;
                regWData = rdR & Sn_IR_CLR_MASK;
                if (ack) nextState = FINISH;
            end
            FINISH: begin
                done      = okR;
                err       = !okR;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath; gap forces one idle bus cycle after every acknowledged request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lenR      <= 16'd0;
            wordsLeft <= 16'd0;
            pollCnt   <= 16'd0;
            wordR     <= 16'd0;
            rdR       <= 16'd0;
            fsrHi     <= 1'b0;
            okR       <= 1'b0;
            gap       <= 1'b0;
        end else begin
            gap <= ack;
            case (state)
                IDLE: if (start) begin
                    okR     <= 1'b0;
                    pollCnt <= 16'd0;
                    if (!lenBad) begin
                        lenR      <= len;
                        wordsLeft <= lenPlus[16:1];
                    end
                end
                RD_FSR0: if (ack) fsrHi <= regRData[0];
                RD_FSR2: if (ack) rdR <= regRData;
                CHK_FSR: if (!freeOk && pollCnt < POLL_MAX) pollCnt <= pollCnt + 16'd1;
                FETCH:   if (dataValid) wordR <= data;
                PUSH:    if (ack) wordsLeft <= wordsLeft - 16'd1;
                WR_CR:   if (ack) pollCnt <= 16'd0;
                RD_IR:   if (ack) rdR <= regRData;
                CHK_IR: begin
                    if (irOk) okR <= 1'b1;
                    else if (!irTimeout && pollCnt < POLL_MAX) pollCnt <= pollCnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_udp_tx_sequencer.sv
// tb/tb_w5300_udp_tx_sequencer.sv - directed bench for the W5300 UDP Tx sequencer
module tb_w5300_udp_tx_sequencer;
    import w5300_udp_tx_sequencer_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  len = 16'd0;
    logic         busy, done, err;
    logic [15:0]  data = 16'd0;
    logic         dataValid = 1'b0;
    logic         dataReady;
    logic         regReq;
    AddrOperation regOp;
    logic [9:0]   regAddr;
    logic [15:0]  regWData;
    logic         regAck = 1'b0;
    logic [15:0]  regRData = 16'd0;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] fsr0Val = 16'h0000;
    logic [15:0] fsr2Val = 16'h2000;
    logic [15:0] irVal = 16'h0010;
    logic        gapMode = 1'b0;
    int          gapCnt = 0;
    logic        hsPending = 1'b0;
    int          idx = 0;
    int          hsCount = 0;
    int          reqCycles = 0;
    int          readySeen = 0;
    int          doneCnt = 0;
    int          errCnt = 0;
    logic [9:0]  logAddr[$];
    logic [15:0] logData[$];
    logic        logWr[$];

    w5300_udp_tx_sequencer #(.SOCKET(0), .MAX_POLLS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .data(data), .dataValid(dataValid), .dataReady(dataReady),
        .regReq(regReq), .regOp(regOp), .regAddr(regAddr), .regWData(regWData),
        .regAck(regAck), .regRData(regRData)
    );

    always #5 clk = ~clk;

    // Bus driver and packet source model; everything updates on the falling edge.
    always @(negedge clk) begin
        if (hsPending) begin
            idx++;
            hsCount++;
            gapCnt = 0;
        end
        dataValid = !gapMode || (gapCnt >= 3);
        if (!dataValid) gapCnt++;
        data = 16'hA000 + 16'(idx);
        hsPending = dataValid && dataReady;

        regAck = regReq && !regAck;
        regRData = 16'h0000;
        if (regAck) begin
            if (regAddr == 10'h224) regRData = fsr0Val;
            else if (regAddr == 10'h226) regRData = fsr2Val;
            else if (regAddr == 10'h206) regRData = irVal;
            logAddr.push_back(regAddr);
            logData.push_back(regOp == WR ? regWData : regRData);
            logWr.push_back(regOp == WR);
        end
        if (regReq) reqCycles++;
        if (dataReady) readySeen++;
        if (done) doneCnt++;
        if (err) errCnt++;
    end

    task automatic clearLogs();
        logAddr.delete();
        logData.delete();
        logWr.delete();
        hsCount = 0;
        reqCycles = 0;
        readySeen = 0;
        doneCnt = 0;
        errCnt = 0;
        idx = 0;
    endtask

    task automatic pulseStart(input logic [15:0] l);
        start = 1'b1;
        len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitEnd(input int maxc, output logic found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done || err) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({busy, done, err, regReq, dataReady} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl got busy/done/err/req/rdy=%b want 00000", {busy, done, err, regReq, dataReady});
        end
        compared++;
        if (regOp !== RD || regAddr !== 10'd0 || regWData !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_bus got op=%0d addr=%h wdata=%h want 0/000/0000", regOp, regAddr, regWData);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic found;
        logic [9:0]  expA[6] = '{10'h22E, 10'h22E, 10'h220, 10'h222, 10'h202, 10'h206};
        logic [15:0] expD[6] = '{16'hA000, 16'hA001, 16'h0000, 16'h0004, 16'h0020, 16'h0010};
        int wi;
        fsr0Val = 16'h0000; fsr2Val = 16'h2000; irVal = 16'h0010;
        clearLogs();
        pulseStart(16'd4);
        compared++;
        if (busy !== 1'b1 || regReq !== 1'b1 || regAddr !== 10'h224) begin
            mismatched++;
            $display("FAIL basic_first_req got busy=%b req=%b addr=%h want 1 1 224", busy, regReq, regAddr);
        end
        waitEnd(300, found);
        compared++;
        if (!found || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done got found=%b done=%b err=%b busy=%b want 1 1 0 0", found, done, err, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (doneCnt !== 1 || errCnt !== 0) begin
            mismatched++;
            $display("FAIL basic_pulse got done=%0d err=%0d want 1 0", doneCnt, errCnt);
        end
        wi = 0;
        for (int i = 0; i < logAddr.size(); i++) begin
            if (logWr[i]) begin
                compared++;
                if (wi >= 6 || logAddr[i] !== expA[wi] || logData[i] !== expD[wi]) begin
                    mismatched++;
                    $display("FAIL basic_write%0d got %h=%h want %h=%h", wi, logAddr[i], logData[i],
                             expA[wi < 6 ? wi : 0], expD[wi < 6 ? wi : 0]);
                end
                wi++;
            end
        end
        compared++;
        if (wi !== 6) begin
            mismatched++;
            $display("FAIL basic_write_count got %0d want 6", wi);
        end
    endtask

    task automatic test_odd_len();
        logic found;
        logic [15:0] wrsr2;
        wrsr2 = 16'hFFFF;
        clearLogs();
        pulseStart(16'd5);
        waitEnd(300, found);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < logAddr.size(); i++)
            if (logWr[i] && logAddr[i] == 10'h222) wrsr2 = logData[i];
        compared++;
        if (!found || hsCount !== 3 || doneCnt !== 1) begin
            mismatched++;
            $display("FAIL odd_handshakes got found=%b hs=%0d done=%0d want 1 3 1", found, hsCount, doneCnt);
        end
        compared++;
        if (wrsr2 !== 16'd5) begin
            mismatched++;
            $display("FAIL odd_wrsr2 got %h want 0005", wrsr2);
        end
    endtask

    task automatic test_reject();
        logic [15:0] bad[2] = '{16'd0, 16'd1473};
        for (int k = 0; k < 2; k++) begin
            clearLogs();
            pulseStart(bad[k]);
            compared++;
            if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                mismatched++;
                $display("FAIL reject_%0d got err=%b busy=%b done=%b want 1 0 0", bad[k], err, busy, done);
            end
            @(posedge clk); #1;
            compared++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reject_pulse_%0d got err=%b busy=%b want 0 0", bad[k], err, busy);
            end
            repeat (3) @(posedge clk);
            #1;
            compared++;
            if (reqCycles !== 0 || errCnt !== 1) begin
                mismatched++;
                $display("FAIL reject_traffic_%0d got req=%0d err=%0d want 0 1", bad[k], reqCycles, errCnt);
            end
        end
    endtask

    task automatic test_fsr_timeout();
        logic found;
        int n0, n2;
        fsr0Val = 16'h0000; fsr2Val = 16'h0000;
        clearLogs();
        pulseStart(16'd4);
        waitEnd(500, found);
        repeat (3) @(posedge clk);
        #1;
        n0 = 0; n2 = 0;
        for (int i = 0; i < logAddr.size(); i++) begin
            if (!logWr[i] && logAddr[i] == 10'h224) n0++;
            if (!logWr[i] && logAddr[i] == 10'h226) n2++;
        end
        compared++;
        if (!found || errCnt !== 1 || doneCnt !== 0) begin
            mismatched++;
            $display("FAIL fsr_abort got found=%b err=%0d done=%0d want 1 1 0", found, errCnt, doneCnt);
        end
        compared++;
        if (n0 !== 8 || n2 !== 8 || logAddr.size() !== 16) begin
            mismatched++;
            $display("FAIL fsr_polls got fsr0=%0d fsr2=%0d total=%0d want 8 8 16", n0, n2, logAddr.size());
        end
        compared++;
        if (readySeen !== 0 || hsCount !== 0) begin
            mismatched++;
            $display("FAIL fsr_no_data got ready=%0d hs=%0d want 0 0", readySeen, hsCount);
        end
        fsr2Val = 16'h2000;
    endtask

    task automatic test_ir_timeout();
        logic found;
        int last;
        irVal = 16'h0008;
        clearLogs();
        pulseStart(16'd2);
        waitEnd(300, found);
        repeat (3) @(posedge clk);
        #1;
        last = logAddr.size() - 1;
        compared++;
        if (!found || errCnt !== 1 || doneCnt !== 0) begin
            mismatched++;
            $display("FAIL irto_result got found=%b err=%0d done=%0d want 1 1 0", found, errCnt, doneCnt);
        end
        compared++;
        if (last < 0 || !logWr[last] || logAddr[last] !== 10'h206 || logData[last] !== 16'h0008) begin
            mismatched++;
            $display("FAIL irto_clear got last=%0d %h=%h want 206=0008", last,
                     last >= 0 ? logAddr[last] : 10'h0, last >= 0 ? logData[last] : 16'h0);
        end
        irVal = 16'h0010;
    endtask

    task automatic test_reset_mid();
        logic found;
        logic inPush;
        clearLogs();
        gapMode = 1'b1;
        pulseStart(16'd8);
        inPush = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (regReq && regOp == WR && regAddr == 10'h22E) begin
                inPush = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        compared++;
        if (!inPush) begin
            mismatched++;
            $display("FAIL midrst_reach_push got 0 want 1");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        compared++;
        if ({busy, done, err, regReq, dataReady} !== 5'b0 || regOp !== RD || regAddr !== 10'd0 || regWData !== 16'd0) begin
            mismatched++;
            $display("FAIL midrst_outputs got ctrl=%b op=%0d addr=%h wd=%h want 00000 0 000 0000",
                     {busy, done, err, regReq, dataReady}, regOp, regAddr, regWData);
        end
        rst = 1'b0;
        gapMode = 1'b0;
        @(posedge clk); #1;
        clearLogs();
        @(posedge clk); #1;
        pulseStart(16'd2);
        waitEnd(300, found);
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (!found || doneCnt !== 1 || errCnt !== 0 || hsCount !== 1) begin
            mismatched++;
            $display("FAIL midrst_resend got found=%b done=%0d err=%0d hs=%0d want 1 1 0 1", found, doneCnt, errCnt, hsCount);
        end
        compared++;
        if (logAddr.size() < 3 || logAddr[0] !== 10'h224 || logAddr[2] !== 10'h22E || logData[2] !== 16'hA000) begin
            mismatched++;
            $display("FAIL midrst_fifo got n=%0d first=%h", logAddr.size(), logAddr.size() > 2 ? logData[2] : 16'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_len();
        test_reject();
        test_fsr_timeout();
        test_ir_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/w5300_udp_tx_sequencer.md
# w5300_udp_tx_sequencer

Sequences one UDP datagram transmission on a single W5300 socket over the shared 16-bit register-access port. Checks free Tx memory, streams payload words into Sn_TX_FIFOR, commits the length through Sn_TX_WRSR, issues SEND, and polls Sn_IR for SENDOK or TIMEOUT. Sits between the packet source (user logic) and the W5300 bus driver that performs the physical read and write cycles.

## Interface
- SOCKET, 0: socket index 0–7; every Sn_* address is derived from it with W5300::get_socket_n_reg.
- MAX_POLLS, 1024: maximum register polls allowed per polling phase before aborting with an error.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  16  payload length in bytes; valid when start is high
- busy  out  1  high from the cycle after an accepted start until done or err
- done  out  1  one-cycle pulse on successful SENDOK
- err  out  1  one-cycle pulse on failure
- data  in  16  payload word, first byte on bits [15:8]
- dataValid  in  1  data is valid
- dataReady  out  1  word consumed when dataValid && dataReady
- regReq  out  1  register transaction request
- regOp  out  1  W5300::AddrOperation (WR or RD)
- regAddr  out  10  register address
- regWData  out  16  write data
- regAck  in  1  one-cycle completion pulse from the bus driver
- regRData  in  16  read data, valid while regAck is high

## Operation
- States, all enumerated in W5300::TxSeqState: IDLE, RD_FSR0, RD_FSR2, CHK_FSR, FETCH, PUSH, WR_WRSR0, WR_WRSR2, WR_CR, RD_IR, CHK_IR, CLR_IR, FINISH.
- IDLE, start=1, len=0 or len>1472 (Sn_MSSR_UDP): err pulses the next cycle. busy stays 0. No register traffic.
- IDLE, valid start: latch len and compute words = (len+1)>>1. A 1-byte final word still consumes a full data word; its bits [7:0] are don't-care. Go to RD_FSR0.
- RD_FSR0 / RD_FSR2: read Sn_TX_FSR0 and Sn_TX_FSR2. The free size is {FSR0[0], FSR2}, 17 bits.
- CHK_FSR:
  - free ≥ len: go to FETCH.
  - otherwise: increment the poll count and return to RD_FSR0.
  - poll count reaching MAX_POLLS: abort. err pulses, go to IDLE. No data is consumed.
- FETCH: dataReady=1. On handshake, latch the word and go to PUSH.
- PUSH: write the latched word to Sn_TX_FIFOR. On regAck, decrement the word count.
  - count 0: go to WR_WRSR0.
  - count nonzero: go to FETCH.
- WR_WRSR0 then WR_WRSR2: write 16'h0000, then len.
- WR_CR: write Sn_CR_SEND. Clear the poll count. Go to RD_IR.
- RD_IR / CHK_IR:
  - SENDOK set: go to CLR_IR; the result is success.
  - TIMEOUT set: go to CLR_IR; the result is failure.
  - neither set: count a poll and loop to RD_IR, or abort with err at MAX_POLLS.
- CLR_IR: write Sn_IR with the observed bits (write-1-to-clear). Go to FINISH.
- FINISH: pulse done or err according to the result, drop busy, return to IDLE.
- start while busy: ignored.
- rst mid-transaction: all state is dropped and regReq deasserts immediately. The bus driver must tolerate an abandoned request.

## Timing
- Reset values: busy=0, done=0, err=0, regReq=0, regOp=RD, regAddr=0, regWData=0, dataReady=0.
- Register handshake:
  - regReq rises on state entry. regOp, regAddr and regWData stay stable until regAck.
  - regReq drops the cycle after regAck. A new request may start the following cycle, giving a minimum of 1 idle cycle between requests.
  - regAck with regReq low is ignored.
- Data handshake: dataReady is high only in FETCH and falls the cycle after the handshake. At most one word is consumed per handshake.
- start to first regReq: 1 cycle.
- Rejection: err pulses the cycle after start.
- done/err: asserted for exactly 1 cycle. busy falls in the same cycle.
- Poll counter: 16 bits; saturates at MAX_POLLS.

## Structure
- W5300 package additions:
  - TxSeqState enum.
  - localparam Sn_IR_CLR_MASK = Sn_IR_IMR_SENDOK | Sn_IR_IMR_TIMEOUT.
  - UDP_MAX_PAYLOAD = Sn_MSSR_UDP.
- Addresses: computed once per state with get_socket_n_reg(Sn_*, SOCKET).
- No sub-module. A single FSM plus word and poll counters.

## Test plan
- SOCKET=0, len=4, FSR reads 0x0000/0x2000, IR reads 0x0010:
  - register writes in order: 0x22E ×2, 0x220=0, 0x222=4, 0x202=0x0020, 0x206=0x0010.
  - done pulses once.
- len=5: exactly 3 data handshakes; WRSR2 written with 5.
- len=0 and len=1473: err the next cycle; zero regReq; busy stays 0.
- FSR returns 0 forever, MAX_POLLS=8: 8 FSR read pairs, then err; dataReady never asserted.
- IR returns 0x0008: Sn_IR written with 0x0008, err pulses, done stays low.
- rst asserted during PUSH with dataValid gaps of 3 cycles:
  - next cycle all outputs are at reset values.
  - a subsequent len=2 send completes normally.
